usb_ep_scheduler: RTL

USB_EP_SCHEDULER -- requirements
Module: usb_ep_scheduler

---
 rtl/usb_ep_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_ep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : usb_ep_scheduler
// Description : Per-token endpoint arbitration for EP0 pass-through, EP1 IN and
//               EP2 OUT; drives handshake, data toggle and FIFO checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_scheduler #(
  parameter int MAX_PKT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rst,
  input  logic       transaction_active,
  input  logic [3:0] endpoint,
  input  logic       direction_in,
  input  logic       setup,
  input  logic       data_strobe,
  input  logic       success,
  input  logic [7:0] data_out,
  output logic [1:0] handshake,
  output logic       data_toggle,
  output logic [7:0] data_in,
  output logic       data_in_valid,
  input  logic       ep0_toggle,
  input  logic [7:0] ep1_data,
  input  logic       ep1_empty,
  output logic       ep1_rd_en,
  output logic       ep1_commit,
  output logic       ep1_abort,
  output logic       ep2_wr_en,
  output logic [7:0] ep2_wr_data,
  input  logic [6:0] ep2_space,
  output logic       ep2_commit,
  output logic       ep2_abort,
  input  logic       ep1_halt,
  input  logic       ep2_halt,
  input  logic [1:0] clr_toggle
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECIDE = 3'd1;
  localparam logic [2:0] S_IN     = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_PASS   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NONE  = 2'b01;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  localparam logic [6:0] MAX_PKT_C = 7'(MAX_PKT);

  logic [2:0] state_q, state_d;
  logic       ta_q;
  logic [6:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [1:0] hs_q, hs_d;
  logic       dtog_q, dtog_d;
  logic [1:0] tog_q, tog_d;
  logic       is_out_q, is_out_d;
  logic       succ_q, succ_d;

  logic       ta_rise;
  logic       run;
  logic       fin_ok;
  logic [1:0] dec_hs;
  logic [2:0] dec_next;
  logic       dec_tog;

  assign ta_rise = transaction_active && !ta_q;
  // Bus reset and core reset both suppress every strobe except the bus-reset abort.
  assign run     = rst && !usb_rst;
  assign fin_ok  = succ_q && !ovf_q;

  always_comb begin
    dec_hs   = HS_NONE;
    dec_next = S_PASS;
    dec_tog  = 1'b0;
    if (endpoint == 4'd0) begin
      dec_hs  = HS_NONE;
      dec_tog = ep0_toggle;
    end else if (endpoint == 4'd1) begin
      dec_tog = tog_q[0];
      if (!direction_in || setup || ep1_halt) begin
        dec_hs = HS_STALL;
      end else if (ep1_empty) begin
        dec_hs = HS_NAK;
      end else begin
        dec_hs   = HS_ACK;
        dec_next = S_IN;
      end
    end else if (endpoint == 4'd2) begin
      dec_tog = tog_q[1];
      if (direction_in || setup || ep2_halt) begin
        dec_hs = HS_STALL;
      end else if (ep2_space < MAX_PKT_C) begin
        dec_hs = HS_NAK;
      end else begin
        dec_hs   = HS_ACK;
        dec_next = S_OUT;
      end
    end else begin
      dec_hs = HS_STALL;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst || usb_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ta_rise) state_d = S_DECIDE;
      S_DECIDE: state_d = dec_next;
      S_IN:     if (!transaction_active) state_d = S_FINISH;
      S_OUT:    if (!transaction_active) state_d = S_FINISH;
      S_PASS:   if (!transaction_active) state_d = S_IDLE;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    handshake     = hs_q;
    data_toggle   = dtog_q;
    data_in       = (state_q == S_IN) ? ep1_data : 8'h00;
    data_in_valid = run && (state_q == S_IN) && !ep1_empty && (count_q < MAX_PKT_C);
    ep1_rd_en     = data_in_valid && data_strobe;
    ep2_wr_en     = run && (state_q == S_OUT) && data_strobe && (count_q < MAX_PKT_C);
    ep2_wr_data   = ep2_wr_en ? data_out : 8'h00;
    ep1_commit    = run && (state_q == S_FINISH) && !is_out_q && fin_ok;
    ep2_commit    = run && (state_q == S_FINISH) &&  is_out_q && fin_ok;
    ep1_abort     = (run && (state_q == S_FINISH) && !is_out_q && !fin_ok) ||
                    (rst && usb_rst && (state_q == S_IN));
    ep2_abort     = (run && (state_q == S_FINISH) &&  is_out_q && !fin_ok) ||
                    (rst && usb_rst && (state_q == S_OUT));
  end

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    hs_d     = hs_q;
    dtog_d   = dtog_q;
    is_out_d = is_out_q;
    succ_d   = succ_q;
    if ((state_q == S_IDLE) && ta_rise) begin
      count_d = 7'd0;
      ovf_d   = 1'b0;
    end
    if (state_q == S_DECIDE) begin
      hs_d     = dec_hs;
      dtog_d   = dec_tog;
      is_out_d = (dec_next == S_OUT);
    end
    if (ep1_rd_en || ep2_wr_en) begin
      count_d = count_q + 7'd1;
    end
    if ((state_q == S_OUT) && data_strobe && (count_q >= MAX_PKT_C)) begin
      ovf_d = 1'b1;
    end
    if (((state_q == S_IN) || (state_q == S_OUT)) && !transaction_active) begin
      succ_d = success;
    end
    // A clear request wins over a same-cycle commit flip.
    tog_d = (tog_q ^ {ep2_commit, ep1_commit}) & ~clr_toggle;
  end

  always_ff @(posedge clk) begin
    if (!rst || usb_rst) begin
      ta_q     <= 1'b0;
      count_q  <= 7'd0;
      ovf_q    <= 1'b0;
      hs_q     <= HS_NONE;
      dtog_q   <= 1'b0;
      tog_q    <= 2'b00;
      is_out_q <= 1'b0;
      succ_q   <= 1'b0;
    end else begin
      ta_q     <= transaction_active;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hs_q     <= hs_d;
      dtog_q   <= dtog_d;
      tog_q    <= tog_d;
      is_out_q <= is_out_d;
      succ_q   <= succ_d;
    end
  end

endmodule
`default_nettype wire
